// File: rtl/uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_drain
// Description : Fetches bytes from an upstream ring buffer and transmits them
//               as 8N1 UART frames, back to back while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_drain #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    output logic       buf_order,
    input  logic [7:0] buf_data,
    input  logic       buf_done,
    output logic       txd,
    output logic       busy,
    output logic       tx_done
);

    localparam int                 c_CNT_W   = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_REQ   = 3'd1;
    localparam logic [2:0] c_S_WAIT  = 3'd2;
    localparam logic [2:0] c_S_START = 3'd3;
    localparam logic [2:0] c_S_DATA  = 3'd4;
    localparam logic [2:0] c_S_STOP  = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_nxt;
    logic [7:0]         r_shreg;
    logic [7:0]         w_shreg_nxt;
    logic               r_buf_order;
    logic               r_txd;
    logic               r_busy;
    logic               r_tx_done;
    logic               w_txd_nxt;
    logic               w_bit_end;

    assign w_bit_end = (r_cnt == c_CNT_MAX);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shreg_nxt   = r_shreg;
        case (r_state)
            c_S_IDLE: begin
                if (en) w_state_nxt = c_S_REQ;
            end
            c_S_REQ: begin
                w_state_nxt = c_S_WAIT;
            end
            c_S_WAIT: begin
                // No acknowledge means the buffer is empty; fall back and retry.
                if (buf_done) begin
                    w_shreg_nxt = buf_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_S_START;
                end else begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = c_S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shreg_nxt = {1'b0, r_shreg[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_nxt = 3'd0;
                        w_state_nxt   = c_S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = en ? c_S_REQ : c_S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Line level is decided from the upcoming state so txd is a clean flop output.
    always_comb begin
        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            c_S_START: w_txd_nxt = 1'b0;
            c_S_DATA:  w_txd_nxt = w_shreg_nxt[0];
            default:   w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shreg     <= 8'h00;
            r_buf_order <= 1'b0;
            r_txd       <= 1'b1;
            r_busy      <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shreg     <= w_shreg_nxt;
            r_buf_order <= (w_state_nxt == c_S_REQ);
            r_txd       <= w_txd_nxt;
            r_busy      <= (w_state_nxt != c_S_IDLE);
            r_tx_done   <= (w_state_nxt == c_S_STOP) && (w_cnt_nxt == c_CNT_MAX);
        end
    end

    assign buf_order = r_buf_order;
    assign txd       = r_txd;
    assign busy      = r_busy;
    assign tx_done   = r_tx_done;

endmodule
`default_nettype wire

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 868, giving the clk cycles per UART bit; the legal range is 2..65535.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rstn  input  1  synchronous, active-low reset.
REQ-004 en  input  1  when high, new bytes may be fetched; when low, no new fetch starts.
REQ-005 buf_order  output  1  registered read request to the upstream byte ring buffer (its o_order).
REQ-006 buf_data  input  8  byte from the ring buffer (its o_data); valid only while buf_done=1.
REQ-007 buf_done  input  1  ring buffer read acknowledge (its o_done); arrives in the cycle after buf_order=1, or never if the buffer is empty.
REQ-008 txd  output  1  registered serial line, 8N1, idle high.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 tx_done  output  1  single-cycle pulse in the last cycle of each stop bit.

Function
REQ-011 The FSM SHALL have the states IDLE, REQ, WAIT, START, DATA and STOP, with a bit-cycle counter of width clog2(CLK_PER_BIT) and a 3-bit bit index.
REQ-012 IDLE SHALL go to REQ when en=1, and otherwise remain in IDLE.
REQ-013 In REQ, buf_order SHALL be 1 for exactly one cycle, and the FSM SHALL then go to WAIT.
REQ-014 buf_order SHALL be 0 in every state except REQ, so that at most one request is outstanding.
REQ-015 In WAIT, if buf_done=1, the FSM SHALL latch buf_data into an 8-bit shift register, clear the counter, and go to START.
REQ-016 In WAIT, if buf_done=0 (buffer empty), the FSM SHALL go to IDLE; when empty with en=1, the block therefore retries every 3 cycles.
REQ-017 In START, txd SHALL be 0 for CLK_PER_BIT cycles, beginning in the cycle after the buf_done cycle.
REQ-018 In DATA, the FSM SHALL drive 8 bits LSB first, each held for CLK_PER_BIT cycles, shifting right and incrementing the bit index at each bit boundary.
REQ-019 DATA SHALL exit to STOP after bit index 7 completes.
REQ-020 In STOP, txd SHALL be 1 for CLK_PER_BIT cycles, and tx_done SHALL be 1 in the final cycle of the stop bit.
REQ-021 After STOP, the FSM SHALL go directly to REQ if en=1 (no idle gap beyond the fetch latency), and otherwise to IDLE.
REQ-022 A frame SHALL last exactly 10*CLK_PER_BIT cycles of txd.
REQ-023 The back-to-back byte period SHALL be 10*CLK_PER_BIT+2 cycles, with txd=1 during REQ and WAIT.
REQ-024 en=0 during START, DATA or STOP SHALL NOT abort the frame; it only prevents the next fetch.
REQ-025 en=0 while in REQ or WAIT SHALL still complete that handshake, and an acknowledged byte SHALL be transmitted.
REQ-026 buf_done=1 in any state other than WAIT SHALL be ignored; this is a protocol violation and SHALL be flagged by a bench assertion.
REQ-027 Counter arithmetic SHALL compare against CLK_PER_BIT-1 with no wrap beyond it, and the bit index SHALL wrap 7->0 only on the exit to STOP.

Reset
REQ-028 When rstn=0 at a rising edge, the next cycle SHALL show state=IDLE, txd=1, buf_order=0, busy=0, tx_done=0, counter=0 and bit index=0.
REQ-029 A reset mid-frame SHALL drop the in-flight byte, return txd to 1 the next cycle, and issue no request until rstn=1 and en=1.
REQ-030 A reset during WAIT SHALL discard any buf_done that arrives in the reset cycle.

Verification
REQ-031 With CLK_PER_BIT=4, the buffer holding 0xA5, and en=1, the bench SHALL check: buf_order pulse, then buf_done next cycle, then txd = 0x4, 1x4, 0x4, 1x4, 0x4, 0x4, 1x4, 0x4, 1x4, 1x4 (40 cycles), with tx_done in cycle 40 only.
REQ-032 With the buffer empty and en=1 for 12 cycles, the bench SHALL check exactly 4 buf_order pulses spaced 3 cycles apart, txd=1 throughout, and tx_done never asserted.
REQ-033 With the buffer holding 0x00 then 0xFF, the bench SHALL check two frames separated by exactly 2 high cycles, with the second frame data bits all 1.
REQ-034 With en dropped to 0 in data bit 3, the bench SHALL check that the frame completes, tx_done pulses, the FSM goes to IDLE, and no further buf_order occurs.
REQ-035 With rstn=0 for one cycle in data bit 5, the bench SHALL check txd=1, busy=0 and buf_order=0 the following cycle, and that the next frame starts cleanly after rstn=1.
REQ-036 With CLK_PER_BIT=2, the buffer holding 0x3C, and a stall cycle inserted before buf_done, the bench SHALL check that the FSM returns to IDLE, re-requests, and then sends a correct 20-cycle frame.
